prv_trap_sequencer: RTL and testbench
=====================================

// Module: prv_trap_sequencer
// PURPOSE
//  Parametrised trap sequencer between the hazard unit and the privilege block. It replaces per-signal
//  exception wiring with cause vectors and prioritises exceptions and interrupts. It also latches
//  epc/badaddr, holds a registered trap request until the priv block accepts it, then sequences the
//  pipeline flush and PC insertion.
//  WFI stalls and xRET redirects are handled here too. Sits between the hazard unit and the priv block.
// PARAMETERS
//  XLEN          32  data/address width of epc, badaddr
//  NUM_EXC       16  exception cause vector width (bit i = exception cause code i)
//  NUM_INT       16  interrupt cause vector width (bit i = interrupt cause code i)
//  FLUSH_CYCLES  2   cycles pipe_clear stays high per redirect (>=1)
//  CW = $clog2(max(NUM_EXC,NUM_INT)); derived, not overridable
// PORTS
//  CLK           in   1        clock, all state on rising edge
//  nRST          in   1        asynchronous active-low reset
//  exc_vec       in   NUM_EXC  exception causes raised this cycle by the hazard unit
//  exc_epc       in   XLEN     PC of the faulting/interrupted instruction
//  exc_badaddr   in   XLEN     faulting address/instruction (tval)
//  int_pending   in   NUM_INT  pending interrupt lines (mip)
//  int_enable    in   NUM_INT  per-line enables (mie)
//  global_ie     in   1        global interrupt enable (mstatus.MIE)
//  ret           in   1        xRET retiring this cycle
//  wfi           in   1        WFI retiring this cycle
//  trap_ready    in   1        priv block accepted trap (CSRs updated)
//  trap_valid    out  1        registered trap request
//  trap_is_intr  out  1        1 = interrupt, 0 = exception
//  trap_cause    out  CW       cause code of the trap
//  trap_epc      out  XLEN     latched epc
//  trap_badaddr  out  XLEN     latched badaddr (0 for interrupts)
//  insert_pc     out  1        one-cycle pulse: fetch must load priv PC
//  pipe_clear    out  1        flush pipeline
//  wfi_stall     out  1        hold pipeline while waiting for interrupt
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; latched epc/badaddr/cause 0. An nRST assertion in any state aborts
//   the operation immediately.
//  Priority: any exc_vec bit beats interrupts. Lowest set exc bit wins. Interrupt candidate is
//   int_pending & int_enable, gated by global_ie. The highest set interrupt bit wins.
//  States:
//   IDLE: an exception or gated interrupt goes to REQ, latching cause, is_intr, exc_epc and
//    badaddr (0 if intr) in that edge.
//    Else ret goes to FLUSH. Else wfi goes to WFI.
//    Exception beats ret and wfi in the same cycle. ret beats wfi.
//   REQ: trap_valid=1, outputs stable. New exc_vec and ret are ignored.
//    On trap_ready=1 go to FLUSH the next edge. trap_ready may be held high; REQ still lasts >=1 cycle.
//   FLUSH: pipe_clear=1 for exactly FLUSH_CYCLES cycles. insert_pc=1 on the first cycle only.
//    Counter counts 0..FLUSH_CYCLES-1, then IDLE. All inputs are ignored while in FLUSH.
//   WFI: wfi_stall=1. When any (int_pending & int_enable) bit is set, global_ie is ignored for wake.
//    Wake with global_ie=1 goes to REQ with the interrupt latched. Wake with global_ie=0 goes to IDLE
//     (resume, no trap).
//    An exc_vec bit in WFI goes to REQ with exception priority.
//  Latency: cause cycle N gives trap_valid at N+1. trap_ready at cycle M gives insert_pc/pipe_clear at M+1.
//  trap_cause is the winning bit index zero-extended to CW. No output is combinational from inputs.
// TESTING
//  exc_vec=0x0004 (illegal), epc=0x100 -> next cycle trap_valid=1, cause=2, is_intr=0, epc=0x100
//  exc_vec=0x0804, int 7 pending+enabled, global_ie=1 -> cause=2, is_intr=0 (exception priority)
//  int_pending=0x0880, enable=0x0880, global_ie=1 -> cause=11, is_intr=1, badaddr=0
//  trap_ready low 5 cycles, exc_vec toggling -> latched outputs unchanged; ready=1 -> insert_pc 1 cycle,
//   pipe_clear 2 cycles
//  wfi=1, then int 3 pending/enabled with global_ie=0 -> wfi_stall drops, no trap_valid; with
//   global_ie=1 -> REQ, cause=3
//  nRST low during FLUSH and during REQ -> all outputs 0 asynchronously; ret and exc same cycle ->
//   exception wins

Source files
------------

// File: rtl/prv_trap_sequencer.sv
// prv_trap_sequencer
//   Trap sequencer between the hazard unit and the privilege block.
//   Prioritises exception/interrupt cause vectors, latches epc/badaddr/cause,
//   holds a registered trap request until the priv block accepts it, then
//   sequences the pipeline flush and PC insertion. Also handles xRET
//   redirects and WFI stalls.
//
// Ports
//   CLK          in   clock, all state on rising edge
//   nRST         in   asynchronous active-low reset
//   exc_vec      in   exception causes (bit i = cause code i)
//   exc_epc      in   PC of the faulting/interrupted instruction
//   exc_badaddr  in   faulting address/instruction (tval)
//   int_pending  in   pending interrupt lines (mip)
//   int_enable   in   per-line interrupt enables (mie)
//   global_ie    in   global interrupt enable (mstatus.MIE)
//   ret          in   xRET retiring this cycle
//   wfi          in   WFI retiring this cycle
//   trap_ready   in   priv block accepted the trap
//   trap_valid   out  registered trap request
//   trap_is_intr out  1 = interrupt, 0 = exception
//   trap_cause   out  winning cause code
//   trap_epc     out  latched epc
//   trap_badaddr out  latched badaddr (0 for interrupts)
//   insert_pc    out  one-cycle pulse: fetch loads priv PC
//   pipe_clear   out  pipeline flush, FLUSH_CYCLES cycles per redirect
//   wfi_stall    out  hold pipeline while waiting for interrupt
module prv_trap_sequencer #(
  parameter  int unsigned XLEN         = 32,
  parameter  int unsigned NUM_EXC      = 16,
  parameter  int unsigned NUM_INT      = 16,
  parameter  int unsigned FLUSH_CYCLES = 2,
  localparam int unsigned MAXN         = (NUM_EXC > NUM_INT) ? NUM_EXC : NUM_INT,
  localparam int unsigned CW           = (MAXN > 1) ? $clog2(MAXN) : 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NUM_EXC-1:0] exc_vec,
  input  logic [XLEN-1:0]    exc_epc,
  input  logic [XLEN-1:0]    exc_badaddr,
  input  logic [NUM_INT-1:0] int_pending,
  input  logic [NUM_INT-1:0] int_enable,
  input  logic               global_ie,
  input  logic               ret,
  input  logic               wfi,
  input  logic               trap_ready,
  output logic               trap_valid,
  output logic               trap_is_intr,
  output logic [CW-1:0]      trap_cause,
  output logic [XLEN-1:0]    trap_epc,
  output logic [XLEN-1:0]    trap_badaddr,
  output logic               insert_pc,
  output logic               pipe_clear,
  output logic               wfi_stall
);

  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FLUSH,
    WFI
  } state_t;

  state_t             state_q, state_d;
  logic [FW-1:0]      flush_cnt;
  logic               flush_last;

  logic               exc_any;
  logic [CW-1:0]      exc_code;
  logic [NUM_INT-1:0] int_cand;
  logic               int_any;
  logic [CW-1:0]      int_code;

  logic               load;
  logic               load_intr;

  // Lowest set exception bit wins.
  always_comb begin
    exc_any  = 1'b0;
    exc_code = '0;
    for (int unsigned i = 0; i < NUM_EXC; i++) begin
      if (exc_vec[i] && !exc_any) begin
        exc_code = CW'(i);
        exc_any  = 1'b1;
      end
    end
  end

  // Highest set interrupt bit wins (later iterations overwrite earlier ones).
  always_comb begin
    int_cand = int_pending & int_enable;
    int_any  = |int_cand;
    int_code = '0;
    for (int unsigned i = 0; i < NUM_INT; i++) begin
      if (int_cand[i]) begin
        int_code = CW'(i);
      end
    end
  end

  assign flush_last = (flush_cnt == FW'(FLUSH_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_intr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exc_any) begin
          state_d = REQ;
          load    = 1'b1;
        end else if (int_any && global_ie) begin
          state_d   = REQ;
          load      = 1'b1;
          load_intr = 1'b1;
        end else if (ret) begin
          state_d = FLUSH;
        end else if (wfi) begin
          state_d = WFI;
        end
      end
      REQ: begin
        if (trap_ready) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_last) begin
          state_d = IDLE;
        end
      end
      WFI: begin
        // Wake ignores global_ie; it only decides trap versus plain resume.
        if (exc_any) begin
          state_d = REQ;
          load    = 1'b1;
        end else if (int_any) begin
          if (global_ie) begin
            state_d   = REQ;
            load      = 1'b1;
            load_intr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flush_cnt <= '0;
    end else if (state_q == FLUSH && !flush_last) begin
      flush_cnt <= flush_cnt + FW'(1);
    end else begin
      flush_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      trap_is_intr <= 1'b0;
      trap_cause   <= '0;
      trap_epc     <= '0;
      trap_badaddr <= '0;
    end else if (load) begin
      trap_is_intr <= load_intr;
      trap_cause   <= load_intr ? int_code : exc_code;
      trap_epc     <= exc_epc;
      trap_badaddr <= load_intr ? '0 : exc_badaddr;
    end
  end

  always_comb begin
    trap_valid = (state_q == REQ);
    pipe_clear = (state_q == FLUSH);
    insert_pc  = (state_q == FLUSH) && (flush_cnt == '0);
    wfi_stall  = (state_q == WFI);
  end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// tb_prv_trap_sequencer
//   Directed scenarios followed by randomized traffic, all checked against a
//   transaction-level reference model (pending request flag, remaining flush
//   cycles, waiting flag) with immediate assertions.
module tb_prv_trap_sequencer;

  localparam int XLEN = 32;
  localparam int NE   = 16;
  localparam int NI   = 16;
  localparam int FC   = 2;
  localparam int CW   = 4;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [NE-1:0]   exc_vec;
  logic [XLEN-1:0] exc_epc;
  logic [XLEN-1:0] exc_badaddr;
  logic [NI-1:0]   int_pending;
  logic [NI-1:0]   int_enable;
  logic            global_ie;
  logic            ret;
  logic            wfi;
  logic            trap_ready;
  logic            trap_valid;
  logic            trap_is_intr;
  logic [CW-1:0]   trap_cause;
  logic [XLEN-1:0] trap_epc;
  logic [XLEN-1:0] trap_badaddr;
  logic            insert_pc;
  logic            pipe_clear;
  logic            wfi_stall;

  prv_trap_sequencer #(
    .XLEN(XLEN), .NUM_EXC(NE), .NUM_INT(NI), .FLUSH_CYCLES(FC)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .exc_vec(exc_vec), .exc_epc(exc_epc), .exc_badaddr(exc_badaddr),
    .int_pending(int_pending), .int_enable(int_enable), .global_ie(global_ie),
    .ret(ret), .wfi(wfi), .trap_ready(trap_ready),
    .trap_valid(trap_valid), .trap_is_intr(trap_is_intr), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .trap_badaddr(trap_badaddr),
    .insert_pc(insert_pc), .pipe_clear(pipe_clear), .wfi_stall(wfi_stall)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: what the sequencer owes the outside world.
  bit              m_valid;
  bit              m_intr;
  bit              m_waiting;
  int              m_cause;
  logic [XLEN-1:0] m_epc;
  logic [XLEN-1:0] m_bad;
  int              m_flush_left;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_bit(input int v);
    return $clog2(v & (~v + 1));
  endfunction

  function automatic int highest_bit(input int v);
    return $clog2(v + 1) - 1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_intr = 0; m_waiting = 0; m_cause = 0;
    m_epc = '0; m_bad = '0; m_flush_left = 0;
  endtask

  task automatic take_exc();
    m_valid = 1; m_intr = 0; m_cause = lowest_bit(int'(exc_vec));
    m_epc = exc_epc; m_bad = exc_badaddr;
  endtask

  task automatic take_int(input int cand);
    m_valid = 1; m_intr = 1; m_cause = highest_bit(cand);
    m_epc = exc_epc; m_bad = '0;
  endtask

  task automatic model_step();
    int cand;
    cand = int'(int_pending & int_enable);
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_valid) begin
      if (trap_ready) begin
        m_valid = 0;
        m_flush_left = FC;
      end
    end else if (m_waiting) begin
      if (exc_vec != 0) begin
        m_waiting = 0; take_exc();
      end else if (cand != 0) begin
        m_waiting = 0;
        if (global_ie) take_int(cand);
      end
    end else begin
      if (exc_vec != 0) take_exc();
      else if (cand != 0 && global_ie) take_int(cand);
      else if (ret) m_flush_left = FC;
      else if (wfi) m_waiting = 1;
    end
  endtask

  task automatic compare_all();
    check("trap_valid",   64'(trap_valid),   64'(m_valid));
    check("trap_is_intr", 64'(trap_is_intr), 64'(m_intr));
    check("trap_cause",   64'(trap_cause),   64'(m_cause));
    check("trap_epc",     64'(trap_epc),     64'(m_epc));
    check("trap_badaddr", 64'(trap_badaddr), 64'(m_bad));
    check("pipe_clear",   64'(pipe_clear),   64'(m_flush_left > 0));
    check("insert_pc",    64'(insert_pc),    64'(m_flush_left == FC));
    check("wfi_stall",    64'(wfi_stall),    64'(m_waiting));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    exc_vec = '0; exc_epc = '0; exc_badaddr = '0;
    int_pending = '0; int_enable = '0; global_ie = 1'b0;
    ret = 1'b0; wfi = 1'b0; trap_ready = 1'b0;
  endtask

  // Called just after a sampled edge: reset mid-cycle, check asynchronously.
  task automatic async_reset(input string tag);
    nRST = 1'b0;
    #1;
    model_reset();
    check({tag, "_valid"}, 64'(trap_valid), 64'd0);
    check({tag, "_clear"}, 64'(pipe_clear), 64'd0);
    compare_all();
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    model_reset();
    #7;
    compare_all();
    #5;
    nRST = 1'b1;

    // Illegal instruction exception.
    exc_vec = 16'h0004; exc_epc = 32'h100; exc_badaddr = 32'hdead_beef;
    tick();
    check("ill_valid", 64'(trap_valid), 64'd1);
    check("ill_cause", 64'(trap_cause), 64'd2);
    check("ill_epc",   64'(trap_epc),   64'h100);
    // Held in REQ while inputs churn.
    for (int i = 0; i < 5; i++) begin
      exc_vec = 16'($urandom); exc_epc = $urandom; exc_badaddr = $urandom;
      ret = 1'($urandom);
      tick();
    end
    check("hold_cause", 64'(trap_cause), 64'd2);
    check("hold_epc",   64'(trap_epc),   64'h100);
    idle_inputs();
    trap_ready = 1'b1;
    tick();
    check("acc_insert", 64'(insert_pc), 64'd1);
    trap_ready = 1'b0;
    tick();
    check("flush2_insert", 64'(insert_pc),  64'd0);
    check("flush2_clear",  64'(pipe_clear), 64'd1);
    tick();
    check("flush_done", 64'(pipe_clear), 64'd0);

    // Exception beats a pending enabled interrupt.
    exc_vec = 16'h0804; exc_epc = 32'h200; exc_badaddr = 32'h44;
    int_pending = 16'h0080; int_enable = 16'h0080; global_ie = 1'b1;
    tick();
    check("prio_cause", 64'(trap_cause),   64'd2);
    check("prio_intr",  64'(trap_is_intr), 64'd0);
    idle_inputs();
    trap_ready = 1'b1;
    repeat (3) tick();
    trap_ready = 1'b0;

    // Highest interrupt wins, badaddr forced to 0.
    int_pending = 16'h0880; int_enable = 16'h0880; global_ie = 1'b1;
    exc_epc = 32'h300; exc_badaddr = 32'h1234;
    tick();
    check("int_cause", 64'(trap_cause),   64'd11);
    check("int_intr",  64'(trap_is_intr), 64'd1);
    check("int_bad",   64'(trap_badaddr), 64'd0);
    idle_inputs();
    trap_ready = 1'b1;
    repeat (3) tick();
    trap_ready = 1'b0;

    // WFI woken with global_ie=0: resume without trap.
    wfi = 1'b1;
    tick();
    check("wfi_stall", 64'(wfi_stall), 64'd1);
    wfi = 1'b0;
    tick();
    int_pending = 16'h0008; int_enable = 16'h0008;
    tick();
    check("wake_stall", 64'(wfi_stall),  64'd0);
    check("wake_valid", 64'(trap_valid), 64'd0);
    idle_inputs();
    // WFI woken with global_ie=1: trap on interrupt 3.
    wfi = 1'b1;
    tick();
    wfi = 1'b0;
    int_pending = 16'h0008; int_enable = 16'h0008; global_ie = 1'b1;
    tick();
    check("wake_int_cause", 64'(trap_cause), 64'd3);
    check("wake_int_valid", 64'(trap_valid), 64'd1);
    idle_inputs();
    async_reset("rst_req");

    // ret and exception together; reset lands in FLUSH.
    exc_vec = 16'h0020; ret = 1'b1; exc_epc = 32'h400;
    tick();
    check("retexc_cause", 64'(trap_cause), 64'd5);
    idle_inputs();
    trap_ready = 1'b1;
    tick();
    trap_ready = 1'b0;
    async_reset("rst_flush");

    // Plain ret, then trap_ready already high when the trap arrives.
    ret = 1'b1;
    tick();
    idle_inputs();
    repeat (2) tick();
    trap_ready = 1'b1; exc_vec = 16'h8000;
    tick();
    check("rdy_held_valid", 64'(trap_valid), 64'd1);
    exc_vec = '0;
    tick();
    check("rdy_held_insert", 64'(insert_pc), 64'd1);
    idle_inputs();
    repeat (2) tick();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      exc_vec     = ($urandom_range(0, 5) == 0) ? 16'($urandom) : '0;
      exc_epc     = $urandom;
      exc_badaddr = $urandom;
      int_pending = ($urandom_range(0, 3) == 0) ? 16'($urandom) : '0;
      int_enable  = 16'($urandom);
      global_ie   = 1'($urandom);
      ret         = ($urandom_range(0, 4) == 0);
      wfi         = ($urandom_range(0, 4) == 0);
      trap_ready  = 1'($urandom);
      tick();
      if ($urandom_range(0, 99) == 0) async_reset("rst_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
